// File: rtl/flex_sample_counter.sv
// Block-oriented sample counter: counts samples up to a programmable terminal value,
// then wraps or halts, and tracks completed blocks and one-shot overruns.
module flex_sample_counter #(
    parameter int unsigned NUM_BITS = 10,
    parameter int unsigned BLK_BITS = 8
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                cnt_up,
    input  logic                clear,
    input  logic                one_shot,
    input  logic [NUM_BITS-1:0] rollover_val,
    output logic [NUM_BITS-1:0] count_out,
    output logic                rollover_flag,
    output logic                block_done,
    output logic [BLK_BITS-1:0] block_count,
    output logic                overrun
);

    logic [NUM_BITS-1:0] r_count;
    logic                r_flag;
    logic                r_done;
    logic [BLK_BITS-1:0] r_blk;
    logic                r_ovr;

    logic [NUM_BITS-1:0] w_count_next;
    logic                w_flag_next;
    logic                w_done_next;
    logic [BLK_BITS-1:0] w_blk_next;
    logic                w_ovr_next;
    logic                w_rv_zero;

    assign w_rv_zero = (rollover_val == '0);

    // Next-state: clear beats cnt_up; a zero terminal value freezes counting
    always_comb begin
        w_count_next = r_count;
        w_done_next  = 1'b0;
        w_blk_next   = r_blk;
        w_ovr_next   = r_ovr;
        if (clear) begin
            w_count_next = '0;
            w_blk_next   = '0;
            w_ovr_next   = 1'b0;
        end else if (cnt_up && !w_rv_zero) begin
            if (r_count < rollover_val) begin
                w_count_next = r_count + NUM_BITS'(1);
                w_done_next  = (w_count_next == rollover_val);
            end else if (!one_shot) begin
                w_count_next = NUM_BITS'(1);
                w_done_next  = (w_count_next == rollover_val);
            end else begin
                w_ovr_next = 1'b1;
            end
            if (w_done_next) begin
                w_blk_next = r_blk + BLK_BITS'(1);
            end
        end
        w_flag_next = (w_count_next == rollover_val) && !w_rv_zero;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_count <= '0;
            r_flag  <= 1'b0;
            r_done  <= 1'b0;
            r_blk   <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_flag  <= w_flag_next;
            r_done  <= w_done_next;
            r_blk   <= w_blk_next;
            r_ovr   <= w_ovr_next;
        end
    end

    assign count_out     = r_count;
    assign rollover_flag = r_flag;
    assign block_done    = r_done;
    assign block_count   = r_blk;
    assign overrun       = r_ovr;

endmodule

// File: tb/tb_flex_sample_counter.sv
// Scoreboard bench for flex_sample_counter: driver pushes model predictions,
// monitor pops and compares one entry per clock edge.
module tb_flex_sample_counter;

    localparam int unsigned NB = 10;
    localparam int unsigned BB = 2;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic          cnt_up = 1'b0;
    logic          clear = 1'b0;
    logic          one_shot = 1'b0;
    logic [NB-1:0] rollover_val = '0;
    logic [NB-1:0] count_out;
    logic          rollover_flag;
    logic          block_done;
    logic [BB-1:0] block_count;
    logic          overrun;

    flex_sample_counter #(.NUM_BITS(NB), .BLK_BITS(BB)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .cnt_up       (cnt_up),
        .clear        (clear),
        .one_shot     (one_shot),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag),
        .block_done   (block_done),
        .block_count  (block_count),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NB-1:0] cnt;
        logic          flag;
        logic          done;
        logic [BB-1:0] blk;
        logic          ov;
    } obs_t;

    obs_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 0;

    // Reference model state in plain integers
    int m_cnt = 0;
    int m_blk = 0;
    bit m_ov  = 0;
    bit m_done = 0;

    function automatic obs_t dut_obs();
        obs_t o;
        o.cnt  = count_out;
        o.flag = rollover_flag;
        o.done = block_done;
        o.blk  = block_count;
        o.ov   = overrun;
        return o;
    endfunction

    function automatic obs_t model_obs(input int rv);
        obs_t o;
        o.cnt  = NB'(m_cnt);
        o.flag = (rv != 0) && (m_cnt == rv);
        o.done = m_done;
        o.blk  = BB'(m_blk);
        o.ov   = m_ov;
        return o;
    endfunction

    function automatic void compare(input string name, input obs_t got, input obs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got cnt=%0d flag=%0b done=%0b blk=%0d ov=%0b, expected cnt=%0d flag=%0b done=%0b blk=%0d ov=%0b",
                     name, $time, got.cnt, got.flag, got.done, got.blk, got.ov,
                     exp.cnt, exp.flag, exp.done, exp.blk, exp.ov);
        end
    endfunction

    // One sample period of the counter's behaviour, stated from its rules
    function automatic void model_step(input bit cu, input bit clr, input bit os, input int rv);
        m_done = 0;
        if (clr) begin
            m_cnt = 0;
            m_blk = 0;
            m_ov  = 0;
        end else if (cu && rv != 0) begin
            if (m_cnt < rv) begin
                m_cnt  = m_cnt + 1;
                m_done = (m_cnt == rv);
            end else if (!os) begin
                m_cnt  = 1;
                m_done = (rv == 1);
            end else begin
                m_ov = 1;
            end
            if (m_done) m_blk = (m_blk + 1) % (1 << BB);
        end
    endfunction

    task automatic cycle(input bit cu, input bit clr, input bit os, input int rv);
        @(negedge clk);
        n_reset      = 1'b1;
        cnt_up       = cu;
        clear        = clr;
        one_shot     = os;
        rollover_val = NB'(rv);
        model_step(cu, clr, os, rv);
        q.push_back(model_obs(rv));
        mon_en = 1;
    endtask

    // Reset asserted mid-cycle: outputs must clear before the next edge
    task automatic do_reset();
        obs_t zero;
        zero = '0;
        @(negedge clk);
        n_reset = 1'b0;
        cnt_up  = 1'b0;
        clear   = 1'b0;
        #1;
        compare("async_reset", dut_obs(), zero);
        m_cnt = 0;
        m_blk = 0;
        m_ov  = 0;
        m_done = 0;
        q.push_back(zero);
        mon_en = 1;
    endtask

    initial begin : monitor
        obs_t exp;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL queue_empty @%0t: got no prediction, expected one per edge", $time);
                end else begin
                    exp = q.pop_front();
                    compare("edge", dut_obs(), exp);
                end
            end
        end
    end

    initial begin : driver
        int rv;
        bit os;
        do_reset();
        do_reset();

        // Wrap over two blocks of 1000
        repeat (2000) cycle(1, 0, 0, 1000);
        cycle(0, 0, 0, 1000);

        // One-shot halt, overrun, clear
        cycle(0, 1, 0, 5);
        repeat (8) cycle(1, 0, 1, 5);
        cycle(0, 1, 1, 5);
        cycle(0, 0, 1, 5);

        // Halted then switched to wrap mode resumes at 1
        repeat (7) cycle(1, 0, 1, 5);
        cycle(1, 0, 0, 5);
        cycle(1, 0, 0, 5);

        // clear wins over cnt_up at count 3
        cycle(0, 1, 0, 10);
        repeat (3) cycle(1, 0, 0, 10);
        cycle(1, 1, 0, 10);
        cycle(0, 0, 0, 10);

        // Gapped counting
        cycle(0, 1, 0, 4);
        repeat (10) begin
            cycle(1, 0, 0, 4);
            cycle(0, 0, 0, 4);
        end

        // Terminal lowered below count, then disabled with zero
        cycle(0, 1, 0, 10);
        repeat (6) cycle(1, 0, 0, 10);
        cycle(0, 0, 0, 3);
        cycle(1, 0, 0, 3);
        cycle(1, 0, 0, 3);
        repeat (4) cycle(1, 0, 0, 0);
        repeat (3) cycle(1, 0, 1, 0);

        // Reset mid-block at 700, then restart from 0
        cycle(0, 1, 0, 1000);
        repeat (700) cycle(1, 0, 0, 1000);
        do_reset();
        cycle(0, 0, 0, 1000);
        repeat (3) cycle(1, 0, 0, 1000);

        // Four blocks wrap the 2-bit block counter to 0
        cycle(0, 1, 0, 3);
        repeat (12) cycle(1, 0, 0, 3);
        cycle(0, 0, 0, 3);
        repeat (4) cycle(1, 0, 0, 1);

        // Randomized traffic
        rv = 4;
        os = 0;
        repeat (500) begin
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 6))
                    0: rv = 0;
                    1: rv = 1;
                    2: rv = 2;
                    3: rv = 3;
                    4: rv = 7;
                    5: rv = 12;
                    default: rv = int'($urandom_range(0, 1023));
                endcase
            end
            if ($urandom_range(0, 49) == 0) os = ~os;
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, os, rv);
        end

        cycle(0, 0, 0, 0);
        @(posedge clk);
        #3;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL queue_drain: got %0d leftover predictions, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flex_sample_counter.md
FLEX_SAMPLE_COUNTER -- requirements
Module: flex_sample_counter

Interface
REQ-001 The module SHALL have parameter NUM_BITS, default 10, giving the width of the sample count and the rollover value.
REQ-002 The module SHALL have parameter BLK_BITS, default 8, giving the width of the completed-block counter.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port n_reset, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The module SHALL have port cnt_up, input, 1 bit: counts one sample per cycle while high.
REQ-006 The module SHALL have port clear, input, 1 bit: synchronous clear of all counting state.
REQ-007 The module SHALL have port one_shot, input, 1 bit: 0 selects wrap mode, 1 selects stop-at-terminal mode.
REQ-008 The module SHALL have port rollover_val, input, NUM_BITS bits: terminal count (block size), sampled every cycle.
REQ-009 The module SHALL have port count_out, output, NUM_BITS bits: current sample count.
REQ-010 The module SHALL have port rollover_flag, output, 1 bit: level, high while count_out equals the nonzero rollover_val.
REQ-011 The module SHALL have port block_done, output, 1 bit: registered one-cycle pulse per completed block.
REQ-012 The module SHALL have port block_count, output, BLK_BITS bits: number of completed blocks, modulo 2^BLK_BITS.
REQ-013 The module SHALL have port overrun, output, 1 bit: sticky, set by cnt_up while halted in one-shot mode.

Function
REQ-014 Priority per cycle SHALL be: n_reset low, then clear, then cnt_up, then hold.
REQ-015 clear high SHALL set count_out, block_count, block_done and overrun to 0 on the next edge, regardless of cnt_up.
REQ-016 cnt_up high with 0 <= count_out < rollover_val SHALL increment count_out by 1, with latency of one edge.
REQ-017 In wrap mode, cnt_up high with count_out >= rollover_val (rollover_val != 0) SHALL load count_out = 1, so the sequence is 1..rollover_val, 1.. .
REQ-018 In one-shot mode, cnt_up high with count_out >= rollover_val (rollover_val != 0) SHALL leave count_out unchanged (halted) and set overrun = 1.
REQ-019 block_done SHALL be 1 in exactly the cycle after the edge on which count_out is loaded with a value equal to rollover_val; otherwise it SHALL be 0.
REQ-020 block_count SHALL increment on the same edge that raises block_done, and SHALL wrap from 2^BLK_BITS-1 to 0 without a flag.
REQ-021 rollover_flag SHALL be registered and SHALL equal (count_out == rollover_val) && (rollover_val != 0), evaluated against the rollover_val sampled on the edge that produced count_out.
REQ-022 rollover_val == 0 SHALL disable counting: count_out SHALL hold, no block_done SHALL occur, and overrun SHALL NOT be set.
REQ-023 If rollover_val is lowered below count_out mid-block, the next cnt_up SHALL behave per REQ-017/REQ-018 without pulsing block_done.
REQ-024 Once set, overrun SHALL remain 1 until clear or reset.
REQ-025 Toggling one_shot from 1 to 0 while halted SHALL resume wrapping on the next cnt_up (count_out -> 1).
REQ-026 All outputs SHALL be driven directly from flops; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-027 n_reset low SHALL immediately force count_out = 0, rollover_flag = 0, block_done = 0, block_count = 0 and overrun = 0, independent of clk.
REQ-028 Reset asserted mid-block SHALL discard the partial count; after release, counting SHALL restart from 0 on the first cnt_up edge.

Verification
REQ-029 Wrap test: NUM_BITS = 10, rollover_val = 1000, one_shot = 0, cnt_up held for 2000 cycles -> block_done pulses twice (cycles 1000 and 2000), block_count = 2, count_out = 1000 with rollover_flag = 1.
REQ-030 One-shot test: rollover_val = 5, one_shot = 1, cnt_up held for 8 cycles -> count_out stops at 5, one block_done pulse, overrun = 1 from the 6th edge; clear -> all outputs 0.
REQ-031 Priority test: clear and cnt_up both high at count_out = 3 -> count_out = 0 next cycle and no block_done.
REQ-032 Gapped input test: cnt_up toggled every other cycle with rollover_val = 4 -> count_out advances only on high cycles, block_done pulses after the 4th high cycle.
REQ-033 Reset test: n_reset asserted asynchronously mid-cycle at count_out = 700 -> outputs 0 before the next edge; BLK_BITS = 2 with 4 blocks completed -> block_count wraps to 0.
REQ-034 Boundary test: rollover_val changed from 10 to 3 at count_out = 6, plus rollover_val = 0 -> count_out -> 1 without block_done; with rollover_val = 0, count_out holds and no flags are raised.
